// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the game-status display stage.
// Game-state encoding and display constants.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HIT,
    OVER
  } state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int         NUM_DIGITS  = 6;
  localparam int         LIVES_W     = 2;

endpackage

// File: rtl/score_display_bcd4_counter.sv
// bcd4_counter: four-digit BCD up-counter.
// Sticks at 9999 instead of wrapping.
module bcd4_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] out
);

  logic [15:0] nxt;
  logic        carry;
  logic        sat;

  assign sat = (out == 16'h9999);

  // ripple a +1 through the BCD digits, units first
  always_comb begin
    nxt   = out;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (out[i*4 +: 4] == 4'd9) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = out[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  // score register
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (inc && !sat) begin
      out <= nxt;
    end
  end

endmodule

// File: rtl/score_display.sv
// score_display: score/lives bookkeeping, game FSM and
// six-digit scan mux feeding the BCD-to-7-segment decoder.
module score_display
  import score_pkg::*;
#(
  parameter int SCAN_BITS  = 15,
  parameter int HIT_HOLD   = 4,
  parameter int LIVES_INIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tick,
  input  logic               coll,
  output logic [2:0]         sel,
  output logic [3:0]         digit,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over
);

  state_t               state_q;
  state_t               state_d;
  logic [LIVES_W-1:0]   lives_d;
  logic [3:0]           hold_q;
  logic [3:0]           hold_d;
  logic                 coll_q;
  logic                 hit_edge;
  logic                 inc;
  logic [15:0]          score;
  logic [SCAN_BITS-1:0] scan_q;
  logic [2:0]           sel_d;
  logic [3:0]           digit_d;

  assign hit_edge = coll & ~coll_q & enable;
  assign inc      = tick & enable &
                    ((state_q == PLAY) | (state_q == HIT));

  bcd4_counter u_score (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .out   (score)
  );

  // next state, lives and hit-immunity hold
  always_comb begin
    state_d = state_q;
    lives_d = lives;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = PLAY;
      end
      PLAY: begin
        if (hit_edge) begin
          if (lives == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d = lives - LIVES_W'(1);
            hold_d  = 4'(HIT_HOLD);
            state_d = HIT;
          end
        end
      end
      HIT: begin
        if (inc) begin
          hold_d = hold_q - 4'd1;
          if (hold_q == 4'd1) state_d = PLAY;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // game state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lives     <= LIVES_W'(LIVES_INIT);
      hold_q    <= '0;
      coll_q    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives     <= lives_d;
      hold_q    <= hold_d;
      coll_q    <= coll;
      game_over <= (state_d == OVER);
    end
  end

  assign sel_d = (&scan_q)
               ? ((sel == 3'(NUM_DIGITS - 1)) ? 3'd0 : sel + 3'd1)
               : sel;

  // pick the code for the digit being selected next
  always_comb begin
    digit_d = DIGIT_BLANK;
    case (sel_d)
      3'd0:    digit_d = score[3:0];
      3'd1:    digit_d = score[7:4];
      3'd2:    digit_d = score[11:8];
      3'd3:    digit_d = score[15:12];
      3'd5:    digit_d = 4'(lives);
      default: digit_d = DIGIT_BLANK;
    endcase
  end

  // scan divider with sel and digit registered together
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q <= '0;
      sel    <= 3'd0;
      digit  <= 4'd0;
    end else begin
      scan_q <= scan_q + SCAN_BITS'(1);
      sel    <= sel_d;
      digit  <= digit_d;
    end
  end

endmodule
